// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: opcodes, FSM states, access sizes.
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

    // Unknown opcodes that still request memory fall back to a word access.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = HALF;
            default:              op_size = WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables, store replication, load extract/extend, alignment check.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  offset,
    input  logic        sign,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        byte_en    = 4'b1111;
        write_data = store_data;
        load_data  = read_data;
        misaligned = 1'b0;
        lane_byte  = '0;
        lane_half  = '0;
        case (size)
            BYTE: begin
                byte_en    = 4'b1000 >> offset;
                write_data = {4{store_data[7:0]}};
                case (offset)
                    2'd0:    lane_byte = read_data[31:24];
                    2'd1:    lane_byte = read_data[23:16];
                    2'd2:    lane_byte = read_data[15:8];
                    default: lane_byte = read_data[7:0];
                endcase
                load_data  = {{24{sign & lane_byte[7]}}, lane_byte};
            end
            HALF: begin
                byte_en    = offset[1] ? 4'b0011 : 4'b1100;
                write_data = {2{store_data[15:0]}};
                lane_half  = offset[1] ? read_data[15:0] : read_data[31:16];
                load_data  = {{16{sign & lane_half[15]}}, lane_half};
                misaligned = offset[0];
            end
            default: begin
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request/acknowledge FSM with watchdog in front of a handshaked data memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [5:0]  MEM_Opcode,
    input  logic [31:0] MEM_ALU_RESULT,
    input  logic [31:0] MEM_RT_DATA,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [3:0]  Mem_Byte_En,
    output logic [31:0] Mem_Wdata,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Rdata,
    output logic        Stall,
    output logic [31:0] Load_Data,
    output logic        Load_Valid,
    output logic        Addr_Error,
    output logic        Bus_Error
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);

    state_t          state, state_nx;
    size_t           size_q, size_d, al_size;
    logic [1:0]      off_q, off_d, al_off;
    logic            sign_q, sign_d, al_sign;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            req, accept, expire;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata, al_load;
    logic            al_misaligned;

    logic        req_d, we_d, load_valid_d, addr_error_d, bus_error_d;
    logic [31:0] addr_d, wdata_d, load_data_d;
    logic [3:0]  be_d;

    // In IDLE the aligner sees the live instruction; afterwards it sees the captured one.
    assign req     = MemRead | MemWrite;
    assign al_size = (state == IDLE) ? op_size(MEM_Opcode)   : size_q;
    assign al_off  = (state == IDLE) ? MEM_ALU_RESULT[1:0]   : off_q;
    assign al_sign = (state == IDLE) ? op_signed(MEM_Opcode) : sign_q;
    assign accept  = (state == IDLE) && req && !al_misaligned;
    assign expire  = (state == ACCESS) && !Mem_Ack && (wd_q == WD_W'(TIMEOUT - 1));
    assign Stall   = (accept && !RESET) || (state == ACCESS);

    mem_lane_align u_align (
        .size       (al_size),
        .offset     (al_off),
        .sign       (al_sign),
        .store_data (MEM_RT_DATA),
        .read_data  (Mem_Rdata),
        .byte_en    (al_be),
        .write_data (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCESS;
            ACCESS:  if (Mem_Ack || expire) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_d        = Mem_Req;
        we_d         = Mem_We;
        addr_d       = Mem_Addr;
        be_d         = Mem_Byte_En;
        wdata_d      = Mem_Wdata;
        load_data_d  = Load_Data;
        load_valid_d = 1'b0;
        addr_error_d = 1'b0;
        bus_error_d  = 1'b0;
        size_d       = size_q;
        off_d        = off_q;
        sign_d       = sign_q;
        wd_d         = wd_q;
        case (state)
            IDLE: begin
                addr_error_d = req && al_misaligned;
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {MEM_ALU_RESULT[31:2], 2'b00};
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    size_d  = al_size;
                    off_d   = al_off;
                    sign_d  = al_sign;
                    wd_d    = '0;
                end
            end
            ACCESS: begin
                if (Mem_Ack) begin
                    req_d = 1'b0;
                    if (!Mem_We) begin
                        load_data_d  = al_load;
                        load_valid_d = 1'b1;
                    end
                end else if (expire) begin
                    req_d       = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Mem_Req     <= 1'b0;
            Mem_We      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_Byte_En <= '0;
            Mem_Wdata   <= '0;
            Load_Data   <= '0;
            Load_Valid  <= 1'b0;
            Addr_Error  <= 1'b0;
            Bus_Error   <= 1'b0;
            size_q      <= WORD;
            off_q       <= '0;
            sign_q      <= 1'b0;
            wd_q        <= '0;
        end else begin
            Mem_Req     <= req_d;
            Mem_We      <= we_d;
            Mem_Addr    <= addr_d;
            Mem_Byte_En <= be_d;
            Mem_Wdata   <= wdata_d;
            Load_Data   <= load_data_d;
            Load_Valid  <= load_valid_d;
            Addr_Error  <= addr_error_d;
            Bus_Error   <= bus_error_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sign_q      <= sign_d;
            wd_q        <= wd_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (watchdog shortened to 4 cycles).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, MemRead, MemWrite, Mem_Ack;
    logic [5:0]  MEM_Opcode;
    logic [31:0] MEM_ALU_RESULT, MEM_RT_DATA, Mem_Rdata;
    logic        Mem_Req, Mem_We, Stall, Load_Valid, Addr_Error, Bus_Error;
    logic [31:0] Mem_Addr, Mem_Wdata, Load_Data;
    logic [3:0]  Mem_Byte_En;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .MEM_Opcode     (MEM_Opcode),
        .MEM_ALU_RESULT (MEM_ALU_RESULT),
        .MEM_RT_DATA    (MEM_RT_DATA),
        .Mem_Req        (Mem_Req),
        .Mem_We         (Mem_We),
        .Mem_Addr       (Mem_Addr),
        .Mem_Byte_En    (Mem_Byte_En),
        .Mem_Wdata      (Mem_Wdata),
        .Mem_Ack        (Mem_Ack),
        .Mem_Rdata      (Mem_Rdata),
        .Stall          (Stall),
        .Load_Data      (Load_Data),
        .Load_Valid     (Load_Valid),
        .Addr_Error     (Addr_Error),
        .Bus_Error      (Bus_Error)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Single-cycle-ack load; returns with the unit in DONE and the request dropped.
    task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        MEM_Opcode = op; MEM_ALU_RESULT = addr; MemRead = 1'b1;
        tick;
        Mem_Ack = 1'b1; Mem_Rdata = rdata;
        tick;
        Mem_Ack = 1'b0; MemRead = 1'b0;
        #1;
    endtask

    initial begin
        RESET = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Mem_Ack = 1'b0;
        MEM_Opcode = OP_LW; MEM_ALU_RESULT = '0; MEM_RT_DATA = '0; Mem_Rdata = '0;
        tick; tick;

        // Reset state, with an aligned load presented while RESET is still high
        MemRead = 1'b1; MEM_ALU_RESULT = 32'h4; #1;
        check1 ("rst_req",   Mem_Req, 1'b0);
        check32("rst_addr",  Mem_Addr, 32'h0);
        check32("rst_be",    32'(Mem_Byte_En), 32'h0);
        check32("rst_ldata", Load_Data, 32'h0);
        check1 ("rst_lv",    Load_Valid, 1'b0);
        check1 ("rst_stall", Stall, 1'b0);
        RESET = 1'b0; MemRead = 1'b0;
        tick;

        // lw 0x4, ack on first ACCESS cycle
        MEM_Opcode = OP_LW; MEM_ALU_RESULT = 32'h4; MemRead = 1'b1; #1;
        check1 ("lw_stall_idle", Stall, 1'b1);
        tick;
        check1 ("lw_req",   Mem_Req, 1'b1);
        check1 ("lw_we",    Mem_We, 1'b0);
        check32("lw_addr",  Mem_Addr, 32'h4);
        check32("lw_be",    32'(Mem_Byte_En), 32'hF);
        check1 ("lw_stall_access", Stall, 1'b1);
        check1 ("lw_lv_access", Load_Valid, 1'b0);
        Mem_Ack = 1'b1; Mem_Rdata = 32'h12345678;
        tick;
        Mem_Ack = 1'b0; MemRead = 1'b0; #1;
        check1 ("lw_lv",    Load_Valid, 1'b1);
        check32("lw_data",  Load_Data, 32'h12345678);
        check1 ("lw_stall_done", Stall, 1'b0);
        check1 ("lw_req_done", Mem_Req, 1'b0);
        tick;
        check1 ("lw_lv_clear", Load_Valid, 1'b0);
        check32("lw_data_hold", Load_Data, 32'h12345678);

        // sb 0x9
        MEM_Opcode = OP_SB; MEM_ALU_RESULT = 32'h9; MEM_RT_DATA = 32'h000000AB; MemWrite = 1'b1;
        tick;
        check1 ("sb_we",    Mem_We, 1'b1);
        check32("sb_addr",  Mem_Addr, 32'h8);
        check32("sb_be",    32'(Mem_Byte_En), 32'h4);
        check32("sb_wdata", Mem_Wdata, 32'hABABABAB);
        Mem_Ack = 1'b1;
        tick;
        Mem_Ack = 1'b0; MemWrite = 1'b0; #1;
        check1 ("sb_lv",    Load_Valid, 1'b0);
        check32("sb_ldata_hold", Load_Data, 32'h12345678);
        tick;

        // Sign/zero extension of byte and halfword loads
        run_load(OP_LB, 32'h2, 32'h0080FF00);
        check1 ("lb_lv",   Load_Valid, 1'b1);
        check32("lb_data", Load_Data, 32'hFFFFFFFF);
        tick;
        run_load(OP_LBU, 32'h2, 32'h0080FF00);
        check32("lbu_data", Load_Data, 32'h000000FF);
        tick;
        run_load(OP_LH, 32'h2, 32'h00008001);
        check32("lh_data", Load_Data, 32'hFFFF8001);
        tick;

        // Misaligned word: error pulse, no request, no stall
        MEM_Opcode = OP_LW; MEM_ALU_RESULT = 32'h6; MemRead = 1'b1; #1;
        check1 ("mis_stall", Stall, 1'b0);
        tick;
        MemRead = 1'b0; #1;
        check1 ("mis_aerr", Addr_Error, 1'b1);
        check1 ("mis_req",  Mem_Req, 1'b0);
        check1 ("mis_lv",   Load_Valid, 1'b0);
        tick;
        check1 ("mis_aerr_clear", Addr_Error, 1'b0);
        check1 ("mis_req_after",  Mem_Req, 1'b0);

        // Watchdog expiry with ack held low
        MEM_Opcode = OP_LW; MEM_ALU_RESULT = 32'h10; MemRead = 1'b1;
        tick;
        for (int i = 1; i <= 4; i++) begin
            check1 ($sformatf("to_req_c%0d", i), Mem_Req, 1'b1);
            check1 ($sformatf("to_berr_c%0d", i), Bus_Error, 1'b0);
            tick;
        end
        MemRead = 1'b0; #1;
        check1 ("to_berr",  Bus_Error, 1'b1);
        check1 ("to_req",   Mem_Req, 1'b0);
        check1 ("to_lv",    Load_Valid, 1'b0);
        check32("to_ldata", Load_Data, 32'h0);
        check1 ("to_stall", Stall, 1'b0);
        tick;
        check1 ("to_berr_clear", Bus_Error, 1'b0);
        check1 ("to_idle_stall", Stall, 1'b0);

        // Ack on the last allowed cycle beats the watchdog
        MEM_Opcode = OP_LW; MEM_ALU_RESULT = 32'h14; MemRead = 1'b1;
        tick;
        for (int i = 1; i <= 3; i++) begin
            check1 ($sformatf("late_req_c%0d", i), Mem_Req, 1'b1);
            tick;
        end
        Mem_Ack = 1'b1; Mem_Rdata = 32'hCAFEF00D;
        tick;
        Mem_Ack = 1'b0; MemRead = 1'b0; #1;
        check1 ("late_berr",  Bus_Error, 1'b0);
        check1 ("late_lv",    Load_Valid, 1'b1);
        check32("late_ldata", Load_Data, 32'hCAFEF00D);
        tick;

        // Reset during the second ACCESS cycle of a store
        MEM_Opcode = OP_SW; MEM_ALU_RESULT = 32'h20; MEM_RT_DATA = 32'hDEADBEEF; MemWrite = 1'b1;
        tick;
        tick;
        check1 ("rs_req_pre",   Mem_Req, 1'b1);
        check32("rs_wdata_pre", Mem_Wdata, 32'hDEADBEEF);
        RESET = 1'b1;
        tick;
        check1 ("rs_req",   Mem_Req, 1'b0);
        check1 ("rs_we",    Mem_We, 1'b0);
        check32("rs_addr",  Mem_Addr, 32'h0);
        check32("rs_be",    32'(Mem_Byte_En), 32'h0);
        check32("rs_wdata", Mem_Wdata, 32'h0);
        check32("rs_ldata", Load_Data, 32'h0);
        check1 ("rs_lv",    Load_Valid, 1'b0);
        check1 ("rs_stall", Stall, 1'b0);
        RESET = 1'b0; MemWrite = 1'b0;
        tick;
        check1 ("rs_lv_after",  Load_Valid, 1'b0);
        check1 ("rs_req_after", Mem_Req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage that sits between the EX/MEM pipeline register and a handshaked data memory, replacing the direct register-to-memory wiring. It decodes the MEM-stage load/store opcode, builds word-aligned addresses, big-endian byte enables and lane-replicated store data, and runs a request/acknowledge FSM with a watchdog. It stalls the pipeline until the access completes and returns sign- or zero-extended load data for the MEM/WB register.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without Mem_Ack before a bus error (≥2).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from EX/MEM control (WB_MEM[1]).
- MemWrite  in  1  store request from EX/MEM control (WB_MEM[0]).
- MEM_Opcode  in  6  instruction opcode held in EX/MEM.
- MEM_ALU_RESULT  in  32  effective byte address.
- MEM_RT_DATA  in  32  store source register value.
- Mem_Req  out  1  memory request, held until Mem_Ack.
- Mem_We  out  1  1 = write, 0 = read; valid while Mem_Req.
- Mem_Addr  out  32  word address, bits [1:0] forced to 0.
- Mem_Byte_En  out  4  byte lanes; bit 3 = bits 31:24.
- Mem_Wdata  out  32  lane-replicated store data.
- Mem_Ack  in  1  memory completion; Mem_Rdata valid the same cycle.
- Mem_Rdata  in  32  read word.
- Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- Load_Data  out  32  extended load result.
- Load_Valid  out  1  Load_Data valid (one cycle).
- Addr_Error  out  1  misaligned access pulse.
- Bus_Error  out  1  watchdog expiry pulse.

## Operation
- Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. Any other opcode with MemRead/MemWrite is treated as word.
- Big-endian: offset 0 → lane 3 (31:24), offset 3 → lane 0 (7:0). Byte: one-hot enable. Half: offset 0 → 4'b1100, offset 2 → 4'b0011. Word: 4'b1111. Loads use the same enables.
- Store data: sb replicates RT[7:0] to all four lanes; sh replicates RT[15:0] twice; sw passes RT.
- Load extract: selected byte/half shifted to bit 0; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0 → Addr_Error for one cycle, no request, no stall, Load_Valid 0.
- MemRead and MemWrite both high: write takes precedence.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: access requested and aligned → register Mem_Addr/Byte_En/Wdata/We and load-type info, clear watchdog, go ACCESS. Otherwise stay.
  - ACCESS: Mem_Req=1. Mem_Ack → capture extended Mem_Rdata (reads only), go DONE. Watchdog reaching TIMEOUT without Mem_Ack → Bus_Error pulse, drop Mem_Req, go DONE with Load_Data=0.
  - DONE: Load_Valid=1 for reads (0 for writes and Bus_Error), Stall=0; go IDLE unconditionally so the same instruction is never re-issued.
- Stall = (IDLE & aligned access requested) | ACCESS. Combinational; everything else registered.

## Timing
- Reset values: state IDLE, Mem_Req 0, Mem_We 0, Mem_Addr 0, Mem_Byte_En 0, Mem_Wdata 0, Load_Data 0, Load_Valid 0, Addr_Error 0, Bus_Error 0, watchdog 0. Stall is 0 while in IDLE with RESET high.
- Minimum access: cycle 0 IDLE (Stall=1), cycle 1 ACCESS with Mem_Ack (Stall=1), cycle 2 DONE (Stall=0, Load_Valid=1). Two stall cycles, plus one per extra ACCESS cycle.
- Mem_Req, Mem_Addr, Mem_Byte_En, Mem_Wdata and Mem_We are stable from ACCESS entry until the Mem_Ack cycle. Mem_Ack outside ACCESS is ignored.
- Watchdog counts ACCESS cycles from 1. Bus_Error is asserted in the cycle where the count equals TIMEOUT and Mem_Ack is low. Mem_Ack in that same cycle wins.
- RESET in any state: next edge returns to IDLE with Mem_Req low. An in-flight access is abandoned with no Load_Valid.
- Load_Data holds its value after DONE until the next load completes.

## Structure
- A shared package holds the opcode constants, the state enum (IDLE/ACCESS/DONE) and the access-size enum (BYTE/HALF/WORD).
- One sub-module, mem_lane_align, is combinational. It takes size, offset and sign and produces byte enables, replicated write data, the extracted/extended load value and the misaligned flag. The FSM and watchdog live in the top module.

## Test plan
- lw addr 0x4, Mem_Ack on the first ACCESS cycle, Rdata 0x12345678 → Mem_Addr 0x4, Byte_En 1111, Stall high 2 cycles, Load_Data 0x12345678 with Load_Valid in cycle 2.
- sb addr 0x9, RT 0x000000AB → Mem_We 1, Mem_Addr 0x8, Byte_En 0100, Wdata 0xABABABAB, no Load_Valid.
- lb addr 0x2 with Rdata 0x0080FF00, then lbu with the same inputs → lb gives Load_Data 0xFFFFFFFF, lbu gives 0x000000FF. lh at 0x2 with Rdata 0x00008001 → 0xFFFF8001.
- lw addr 0x6 → Addr_Error 1 for one cycle, Mem_Req never high, Stall 0.
- TIMEOUT=4 with Mem_Ack held low → Bus_Error on the 4th ACCESS cycle, then DONE with Load_Valid 0, then IDLE. Repeat with Mem_Ack on the 4th cycle → normal completion, no Bus_Error.
- RESET asserted in the 2nd ACCESS cycle → next edge IDLE, Mem_Req 0, all outputs at reset values, no Load_Valid.
